level_border_ctrl: RTL and testbench
====================================

LEVEL_BORDER_CTRL -- requirements
Module: level_border_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- LEVELS, 4: number of green level rings, 1..8.
- LOCK_CYCLES, 300_000_000: lockout length in CLK cycles after an accepted press, ≥2.
- WRAP, 1: 1 = wrap-around at the ends, 0 = saturate.
- OLED_W, 96: display width in pixels.
- OLED_H, 64: display height in pixels.
REQ-002 Ports (name, direction, width, meaning), one per line:
- CLK, in, 1: sole clock.
- reset_n, in, 1: asynchronous active-low reset.
- btn_up, in, 1: debounced up-button level.
- btn_dn, in, 1: debounced down-button level.
- pixel_index, in, 13: raster pixel index, row-major.
- level, out, 4: current level, 0..LEVELS.
- locked, out, 1: lockout active.
- pixel_data, out, 16: RGB565 colour for pixel_index.

Function
REQ-003 An internal previous-value register per button SHALL detect rising edges: edge = btn & ~prev.
REQ-004 The controller SHALL have two states, IDLE (locked=0) and LOCK (locked=1).
REQ-005 In IDLE, an up edge alone SHALL set level to level+1 and a down edge alone SHALL set level to level-1, both taking effect the cycle after the edge, and SHALL enter LOCK.
REQ-006 At the upper boundary (up at level=LEVELS): with WRAP=1 level SHALL become 0 and LOCK SHALL be entered; with WRAP=0 level and state SHALL be unchanged.
REQ-007 At the lower boundary (down at level=0): with WRAP=1 level SHALL become LEVELS and LOCK SHALL be entered; with WRAP=0 level and state SHALL be unchanged.
REQ-008 Simultaneous up and down edges in the same cycle SHALL be ignored: no level change, no lockout.
REQ-009 Edges arriving in LOCK SHALL be ignored, including an edge in the final LOCK cycle.
REQ-010 Entering LOCK SHALL clear the lock counter to 0; the counter SHALL increment each cycle in LOCK; at count LOCK_CYCLES-1 the next state SHALL be IDLE and the counter SHALL clear to 0.
REQ-011 locked SHALL be high for exactly LOCK_CYCLES cycles per accepted press.
REQ-012 Pixel coordinates SHALL be derived as x = pixel_index mod OLED_W and y = pixel_index div OLED_W.
REQ-013 Ring(i, th) SHALL be the set of pixels inside the rectangle [i, OLED_W-1-i] x [i, OLED_H-1-i] and outside the rectangle [i+th, OLED_W-1-i-th] x [i+th, OLED_H-1-i-th].
REQ-014 Colour priority, evaluated first match wins:
- Ring(4,1): red 16'hF800.
- Ring(8,3): orange {5'h1F, 6'b101001, 5'h00}.
- Ring(12+2k,1) for k=0..LEVELS-1 with level > k: green 16'h07E0.
- Otherwise: black 16'h0000.
REQ-015 pixel_data SHALL be registered, valid exactly 1 cycle after pixel_index, and SHALL use the level value registered in that same cycle.
REQ-016 pixel_index ≥ OLED_W*OLED_H SHALL produce black.

Reset
REQ-017 Asserting reset_n low SHALL immediately force level=0, locked=0, state=IDLE, lock counter=0, both prev registers=0, and pixel_data=0, including when reset occurs mid-lockout.
REQ-018 After reset_n deasserts, a button that is already held high SHALL produce an edge on the first clock.

Structure
REQ-019 Colour constants (RED, ORANGE, GREEN, BLACK), the ring insets (4, 8, 12) and thicknesses (1, 3), and the state encoding SHALL live in shared package display_pkg.
REQ-020 Ring membership SHALL be one combinational sub-module, ring_hit (inputs x, y, inset, thickness; output hit), instantiated LEVELS+2 times via generate.

Verification
REQ-021 The bench SHALL use LOCK_CYCLES=10 and LEVELS=4, and SHALL cover:
- Reset, then one up pulse -> level=1 one cycle later; locked high for exactly 10 cycles.
- Up pulse at cycle 3 of lockout -> ignored, level stays 1.
- WRAP=1, level=4, up pulse -> level=0; WRAP=0, same stimulus -> level=4 and locked stays 0.
- Up and down rising in the same cycle -> level unchanged, locked=0.
- level=2, pixel_index=14*96+48 -> green; pixel_index=16*96+48 -> black; pixel_index=4*96+48 -> red; pixel_index=9*96+48 -> orange; each one cycle after the index is applied.
- reset_n low at cycle 5 of lockout -> level=0 and locked=0 asynchronously; next up pulse is accepted.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the level/border display: RGB565 colours, ring geometry
// and the lockout controller state encoding.
`timescale 1ns/1ps
package display_pkg;

   localparam int COORD_W = 13;
   localparam int INSET_W = 5;
   localparam int THICK_W = 2;

   localparam logic [15:0] RED    = 16'hF800;
   localparam logic [15:0] ORANGE = {5'h1F, 6'b101001, 5'h00};
   localparam logic [15:0] GREEN  = 16'h07E0;
   localparam logic [15:0] BLACK  = 16'h0000;

   localparam logic [INSET_W-1:0] RED_INSET    = 5'd4;
   localparam logic [INSET_W-1:0] ORANGE_INSET = 5'd8;
   localparam logic [INSET_W-1:0] GREEN_INSET  = 5'd12;
   localparam logic [INSET_W-1:0] GREEN_STEP   = 5'd2;

   localparam logic [THICK_W-1:0] RED_THICK    = 2'd1;
   localparam logic [THICK_W-1:0] ORANGE_THICK = 2'd3;
   localparam logic [THICK_W-1:0] GREEN_THICK  = 2'd1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } ctrl_state_e;

   // Inset of the k-th green level ring; rings step inwards from GREEN_INSET.
   function automatic logic [INSET_W-1:0] green_inset(input int k);
      return GREEN_INSET + INSET_W'(int'(GREEN_STEP) * k);
   endfunction

endpackage

// File: rtl/ring_hit.sv
// Combinational test of whether pixel (x, y) lies on the rectangular ring of
// the given inset and thickness inside an OLED_W x OLED_H frame.
`timescale 1ns/1ps
module ring_hit
   import display_pkg::*;
#(
   parameter int OLED_W = 96,
   parameter int OLED_H = 64
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [INSET_W-1:0] inset,
   input  logic [THICK_W-1:0] thickness,
   output logic               hit
);

   // Signed bounds so an inner rectangle that collapses past zero stays empty.
   localparam int SW = COORD_W + 3;
   typedef logic signed [SW-1:0] coord_t;

   coord_t xs, ys;
   coord_t o_lo, o_hx, o_hy;
   coord_t i_lo, i_hx, i_hy;
   logic   in_outer, in_inner;

   always_comb begin
      xs   = {3'b000, x};
      ys   = {3'b000, y};
      o_lo = {{(SW-INSET_W){1'b0}}, inset};
      i_lo = o_lo + {{(SW-THICK_W){1'b0}}, thickness};
      o_hx = coord_t'(OLED_W - 1) - o_lo;
      o_hy = coord_t'(OLED_H - 1) - o_lo;
      i_hx = coord_t'(OLED_W - 1) - i_lo;
      i_hy = coord_t'(OLED_H - 1) - i_lo;

      in_outer = (xs >= o_lo) && (xs <= o_hx) && (ys >= o_lo) && (ys <= o_hy);
      in_inner = (xs >= i_lo) && (xs <= i_hx) && (ys >= i_lo) && (ys <= i_hy);
      hit      = in_outer && !in_inner;
   end

endmodule

// File: rtl/level_border_ctrl.sv
// Button-driven level counter with post-press lockout, and a registered
// pixel colour generator drawing red/orange borders plus green level rings.
`timescale 1ns/1ps
module level_border_ctrl
   import display_pkg::*;
#(
   parameter int LEVELS      = 4,
   parameter int LOCK_CYCLES = 300_000_000,
   parameter bit WRAP        = 1'b1,
   parameter int OLED_W      = 96,
   parameter int OLED_H      = 64
) (
   input  logic        CLK,
   input  logic        reset_n,
   input  logic        btn_up,
   input  logic        btn_dn,
   input  logic [12:0] pixel_index,
   output logic [3:0]  level,
   output logic        locked,
   output logic [15:0] pixel_data
);

   localparam int               CNT_W     = $clog2(LOCK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [3:0]       LEVEL_MAX = 4'(LEVELS);
   localparam int               NUM_PIX   = OLED_W * OLED_H;

   ctrl_state_e      state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       level_n;
   logic             prev_up, prev_dn;
   logic             up_edge, dn_edge;

   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         prev_up <= 1'b0;
         prev_dn <= 1'b0;
      end else begin
         prev_up <= btn_up;
         prev_dn <= btn_dn;
      end
   end

   assign up_edge = btn_up & ~prev_up;
   assign dn_edge = btn_dn & ~prev_dn;

   // NOTE: every output is given its hold value first so no path infers a latch.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      level_n = level;
      unique case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (up_edge && !dn_edge) begin
               if (level != LEVEL_MAX) begin
                  level_n = level + 4'd1;
                  state_n = ST_LOCK;
               end else if (WRAP) begin
                  level_n = 4'd0;
                  state_n = ST_LOCK;
               end
            end else if (dn_edge && !up_edge) begin
               if (level != 4'd0) begin
                  level_n = level - 4'd1;
                  state_n = ST_LOCK;
               end else if (WRAP) begin
                  level_n = LEVEL_MAX;
                  state_n = ST_LOCK;
               end
            end
         end
         ST_LOCK: begin
            if (cnt == CNT_LAST) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         level <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         level <= level_n;
      end
   end

   assign locked = (state == ST_LOCK);

   logic [COORD_W-1:0] px, py;
   logic [LEVELS+1:0]  hit;

   assign px = pixel_index % COORD_W'(OLED_W);
   assign py = pixel_index / COORD_W'(OLED_W);

   // Slot 0 is the red border, slot 1 the orange band, the rest are level rings.
   for (genvar g = 0; g < LEVELS + 2; g++) begin : g_ring
      localparam logic [INSET_W-1:0] INS = (g == 0) ? RED_INSET :
                                           (g == 1) ? ORANGE_INSET : green_inset(g - 2);
      localparam logic [THICK_W-1:0] THK = (g == 0) ? RED_THICK :
                                           (g == 1) ? ORANGE_THICK : GREEN_THICK;
      ring_hit #(
         .OLED_W (OLED_W),
         .OLED_H (OLED_H)
      ) u_ring (
         .x         (px),
         .y         (py),
         .inset     (INS),
         .thickness (THK),
         .hit       (hit[g])
      );
   end

   logic [15:0] colour;
   logic        green_any;
   logic        in_range;

   always_comb begin
      green_any = 1'b0;
      for (int k = 0; k < LEVELS; k++) begin
         if (hit[k+2] && (int'(level) > k)) green_any = 1'b1;
      end
      in_range = int'(pixel_index) < NUM_PIX;
      colour   = BLACK;
      if (!in_range)      colour = BLACK;
      else if (hit[0])    colour = RED;
      else if (hit[1])    colour = ORANGE;
      else if (green_any) colour = GREEN;
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) pixel_data <= 16'h0000;
      else          pixel_data <= colour;
   end

endmodule

// File: tb/tb_level_border_ctrl.sv
// Bench for level_border_ctrl: a wrapping and a saturating instance share one
// stimulus stream and are checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_level_border_ctrl;

   localparam int LEVELS = 4;
   localparam int LOCK   = 10;
   localparam int W      = 96;
   localparam int H      = 64;

   localparam logic [31:0] C_RED    = 32'hF800;
   localparam logic [31:0] C_ORANGE = 32'hFD20;
   localparam logic [31:0] C_GREEN  = 32'h07E0;
   localparam logic [31:0] C_BLACK  = 32'h0000;

   logic        CLK = 1'b0;
   logic        reset_n = 1'b0;
   logic        btn_up = 1'b0;
   logic        btn_dn = 1'b0;
   logic [12:0] pixel_index = '0;

   logic [3:0]  lvl_w, lvl_s;
   logic        lk_w, lk_s;
   logic [15:0] pix_w, pix_s;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   level_border_ctrl #(.LEVELS(LEVELS), .LOCK_CYCLES(LOCK), .WRAP(1'b1), .OLED_W(W), .OLED_H(H)) u_wrap (
      .CLK(CLK), .reset_n(reset_n), .btn_up(btn_up), .btn_dn(btn_dn),
      .pixel_index(pixel_index), .level(lvl_w), .locked(lk_w), .pixel_data(pix_w)
   );

   level_border_ctrl #(.LEVELS(LEVELS), .LOCK_CYCLES(LOCK), .WRAP(1'b0), .OLED_W(W), .OLED_H(H)) u_sat (
      .CLK(CLK), .reset_n(reset_n), .btn_up(btn_up), .btn_dn(btn_dn),
      .pixel_index(pixel_index), .level(lvl_s), .locked(lk_s), .pixel_data(pix_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference colour from the ring definitions, in plain integer geometry.
   function automatic bit in_rect(int x, int y, int x0, int x1, int y0, int y1);
      return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
   endfunction

   function automatic bit in_ring(int x, int y, int i, int th);
      return in_rect(x, y, i, W-1-i, i, H-1-i) &&
             !in_rect(x, y, i+th, W-1-i-th, i+th, H-1-i-th);
   endfunction

   function automatic logic [15:0] colour_ref(int idx, int lvl);
      int x, y;
      x = idx % W;
      y = idx / W;
      if (idx >= W*H) return 16'h0000;
      if (in_ring(x, y, 4, 1)) return 16'hF800;
      if (in_ring(x, y, 8, 3)) return 16'hFD20;
      for (int k = 0; k < LEVELS; k++)
         if (lvl > k && in_ring(x, y, 12 + 2*k, 1)) return 16'h07E0;
      return 16'h0000;
   endfunction

   // Model: index 0 wraps, index 1 saturates; lock_m counts remaining lockout cycles.
   int          lvl_m[2]  = '{0, 0};
   int          lock_m[2] = '{0, 0};
   logic [15:0] pix_m[2]  = '{16'h0, 16'h0};
   bit          prev_up_m = 1'b0;
   bit          prev_dn_m = 1'b0;
   wire         ue_m = btn_up & ~prev_up_m;
   wire         de_m = btn_dn & ~prev_dn_m;

   always @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         prev_up_m <= 1'b0;
         prev_dn_m <= 1'b0;
         for (int j = 0; j < 2; j++) begin
            lvl_m[j]  <= 0;
            lock_m[j] <= 0;
            pix_m[j]  <= 16'h0;
         end
      end else begin
         prev_up_m <= btn_up;
         prev_dn_m <= btn_dn;
         for (int j = 0; j < 2; j++) begin
            pix_m[j] <= colour_ref(int'(pixel_index), lvl_m[j]);
            if (lock_m[j] > 0) begin
               lock_m[j] <= lock_m[j] - 1;
            end else if (ue_m && !de_m) begin
               if (lvl_m[j] < LEVELS) begin
                  lvl_m[j] <= lvl_m[j] + 1;  lock_m[j] <= LOCK;
               end else if (j == 0) begin
                  lvl_m[j] <= 0;             lock_m[j] <= LOCK;
               end
            end else if (de_m && !ue_m) begin
               if (lvl_m[j] > 0) begin
                  lvl_m[j] <= lvl_m[j] - 1;  lock_m[j] <= LOCK;
               end else if (j == 0) begin
                  lvl_m[j] <= LEVELS;        lock_m[j] <= LOCK;
               end
            end
         end
      end
   end

   always @(posedge CLK) begin
      #2;
      check("level_wrap",  32'(lvl_w), lvl_m[0]);
      check("locked_wrap", 32'(lk_w),  (lock_m[0] > 0) ? 1 : 0);
      check("pixel_wrap",  32'(pix_w), 32'(pix_m[0]));
      check("level_sat",   32'(lvl_s), lvl_m[1]);
      check("locked_sat",  32'(lk_s),  (lock_m[1] > 0) ? 1 : 0);
      check("pixel_sat",   32'(pix_s), 32'(pix_m[1]));
   end

   task automatic tick();
      @(posedge CLK);
      #4;
   endtask

   task automatic press(input bit up, input bit dn);
      btn_up = up;
      btn_dn = dn;
      tick();
      btn_up = 1'b0;
      btn_dn = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3*LOCK && (lk_w || lk_s); i++) tick();
      check("idle_timeout", 32'(lk_w | lk_s), 0);
   endtask

   task automatic pix_check(input string name, input int idx, input logic [31:0] exp);
      pixel_index = 13'(idx);
      tick();
      check(name, 32'(pix_w), exp);
      check(name, 32'(pix_s), exp);
   endtask

   initial begin
      int n_lock;
      repeat (3) tick();
      check("rst_level",  32'(lvl_w), 0);
      check("rst_locked", 32'(lk_w),  0);
      check("rst_pixel",  32'(pix_w), 0);
      reset_n = 1'b1;
      tick();

      // Accepted press, lockout length, and an edge in the final lockout cycle.
      press(1'b1, 1'b0);
      check("up_level", 32'(lvl_w), 1);
      n_lock = 0;
      for (int i = 0; i < LOCK; i++) begin
         if (lk_w) n_lock++;
         if (i < LOCK - 1) tick();
      end
      press(1'b1, 1'b0);
      check("lock_len",        n_lock, LOCK);
      check("last_cycle_edge", 32'(lvl_w), 1);
      check("lock_released",   32'(lk_w), 0);

      tick();
      press(1'b1, 1'b0);
      check("second_up", 32'(lvl_w), 2);
      tick();
      tick();
      press(1'b1, 1'b0);
      check("up_in_lock",   32'(lvl_w), 2);
      check("still_locked", 32'(lk_w), 1);
      wait_idle();

      press(1'b1, 1'b1);
      check("both_level",  32'(lvl_w), 2);
      check("both_locked", 32'(lk_w), 0);

      pix_check("pix_green",  14*W + 48, C_GREEN);
      pix_check("pix_black",  16*W + 48, C_BLACK);
      pix_check("pix_red",    4*W + 48,  C_RED);
      pix_check("pix_orange", 9*W + 48,  C_ORANGE);
      pix_check("pix_corner", 12*W + 12, C_GREEN);
      pix_check("pix_range",  6200,      C_BLACK);

      press(1'b1, 1'b0);
      wait_idle();
      press(1'b1, 1'b0);
      wait_idle();
      check("at_top", 32'(lvl_w), 4);
      press(1'b1, 1'b0);
      check("wrap_top_level",  32'(lvl_w), 0);
      check("wrap_top_locked", 32'(lk_w),  1);
      check("sat_top_level",   32'(lvl_s), 4);
      check("sat_top_locked",  32'(lk_s),  0);
      wait_idle();
      press(1'b0, 1'b1);
      check("wrap_bottom_level", 32'(lvl_w), 4);
      check("sat_down_level",    32'(lvl_s), 3);
      wait_idle();

      // Asynchronous reset in lockout cycle 5.
      press(1'b1, 1'b0);
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      check("async_level_w",  32'(lvl_w), 0);
      check("async_locked_w", 32'(lk_w),  0);
      check("async_pixel_w",  32'(pix_w), 0);
      check("async_level_s",  32'(lvl_s), 0);
      check("async_locked_s", 32'(lk_s),  0);
      tick();
      reset_n = 1'b1;
      tick();
      press(1'b1, 1'b0);
      check("post_reset_up", 32'(lvl_w), 1);
      wait_idle();

      // Button already held while reset releases.
      reset_n = 1'b0;
      btn_up  = 1'b1;
      tick();
      reset_n = 1'b1;
      tick();
      btn_up = 1'b0;
      check("held_through_reset", 32'(lvl_w), 1);
      wait_idle();

      for (int c = 0; c < 3000; c++) begin
         btn_up = ($urandom_range(0, 2) == 0);
         btn_dn = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) btn_dn = btn_up;
         pixel_index = 13'($urandom_range(0, 6400));
         if ($urandom_range(0, 599) == 0) begin
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
         end else begin
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
